// File: rtl/bcd_event_counter.sv
// Six-digit BCD event counter with start/stop/clear control and a synchronised event input.
// Define BCD_CNT_SATURATE_EN to hold the count at 999999 instead of wrapping to 000000.
module bcd_event_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            evt_in,
    input  logic            start,
    input  logic            stop,
    input  logic            clear,
    output logic [5:0][3:0] reg_cnt_cod,
    output logic            sw_led_ena,
    output logic            ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   evt_pulse;
    logic [5:0][3:0]        cnt;
    logic [5:0][3:0]        cnt_inc;
    logic                   carry;
    logic                   cnt_full;

    // Synchroniser, edge detect and a registered one-cycle event pulse.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            evt_pulse <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], evt_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
            evt_pulse <= sync_q[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    // Single-cycle decimal ripple: each digit at 9 rolls over and passes the carry up.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (cnt[i] == 4'd9) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    assign cnt_full = (cnt == 24'h999999);

    // clear outranks start/stop and leaves the state where it is.
    always_comb begin
        state_nxt = state;
        if (!clear) begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (stop)  state_nxt = HOLD;
                HOLD:    if (start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            reg_cnt_cod <= '0;
            sw_led_ena  <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state      <= state_nxt;
            sw_led_ena <= (state != IDLE);
            if (clear) begin
                cnt         <= '0;
                ovf         <= 1'b0;
                reg_cnt_cod <= '0;
            end else begin
                // The live count is frozen outside RUN, so HOLD keeps showing the stop-cycle value.
                reg_cnt_cod <= (state == IDLE) ? '0 : cnt;
                if (state == RUN && evt_pulse) begin
                    if (cnt_full) ovf <= 1'b1;
`ifdef BCD_CNT_SATURATE_EN
                    if (!cnt_full) cnt <= cnt_inc;
`else
                    cnt <= cnt_inc;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench for bcd_event_counter: integer-count reference model compared every cycle,
// plus directed literal checks of the reset, counting, latency, wrap, clear and command-pair cases.
module tb_bcd_event_counter;

    localparam int S  = 2;
    localparam int HL = S + 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            evt_in;
    logic            start;
    logic            stop;
    logic            clear;
    logic [5:0][3:0] reg_cnt_cod;
    logic            sw_led_ena;
    logic            ovf;
    logic            load_req = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int   m_mode;
    int   m_cnt;
    int   m_disp;
    bit   m_led;
    bit   m_ovf;
    bit   m_valid = 1'b0;
    bit   hist [HL];

    bcd_event_counter #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .evt_in      (evt_in),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .reg_cnt_cod (reg_cnt_cod),
        .sw_led_ena  (sw_led_ena),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // An event sampled high S+1 edges ago after a low sample S+2 edges ago counts on this edge.
    task automatic model_step();
        bit pulse;
        if (rst) begin
            m_mode  = M_IDLE;
            m_cnt   = 0;
            m_disp  = 0;
            m_led   = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
            for (int j = 0; j < HL; j++) hist[j] = 1'b0;
        end else begin
            if (load_req) m_cnt = 999999;
            for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = evt_in;
            pulse  = hist[S+1] && !hist[S+2];
            m_led  = (m_mode != M_IDLE);
            m_disp = (clear || m_mode == M_IDLE) ? 0 : m_cnt;
            if (clear) begin
                m_cnt = 0;
                m_ovf = 1'b0;
            end else begin
                if (m_mode == M_RUN && pulse) begin
                    if (m_cnt == 999999) begin
                        m_ovf = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
                        m_cnt = 0;
`endif
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                if (m_mode == M_RUN && stop) m_mode = M_HOLD;
                else if (m_mode != M_RUN && start) m_mode = M_RUN;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("cycle_reg_cnt_cod", {8'h0, reg_cnt_cod}, {8'h0, to_bcd(m_disp)});
            check("cycle_sw_led_ena", {31'h0, sw_led_ena}, {31'h0, m_led});
            check("cycle_ovf", {31'h0, ovf}, {31'h0, m_ovf});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        evt_in = 1'b1;
        tick(hi);
        evt_in = 1'b0;
        tick(lo);
    endtask

    task automatic cmd(input bit do_start, input bit do_stop, input bit do_clear);
        start = do_start;
        stop  = do_stop;
        clear = do_clear;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; evt_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        tick(2);
        rst = 1'b0;

        // 1: idle, event toggling and stop ignored
        for (int i = 0; i < 5; i++) begin
            evt_in = ~evt_in;
            tick(1);
        end
        cmd(1'b0, 1'b1, 1'b0);
        evt_in = 1'b0;
        tick(6);
        check("idle_cnt", {8'h0, reg_cnt_cod}, 32'h0);
        check("idle_led", {31'h0, sw_led_ena}, 32'h0);
        check("idle_ovf", {31'h0, ovf}, 32'h0);

        // 2: twelve pulses, then hold
        cmd(1'b1, 1'b0, 1'b0);
        repeat (12) pulse(4, 4);
        tick(2);
        cmd(1'b0, 1'b1, 1'b0);
        tick(3);
        check("hold_cnt_12", {8'h0, reg_cnt_cod}, 32'h000012);
        check("hold_led", {31'h0, sw_led_ena}, 32'h1);
        repeat (3) pulse(2, 2);
        tick(4);
        check("hold_ignores_pulses", {8'h0, reg_cnt_cod}, 32'h000012);

        // 3: latency from first high sample to display update
        cmd(1'b1, 1'b0, 1'b0);
        tick(2);
        evt_in = 1'b1;
        tick(4);
        check("latency_k3_unchanged", {8'h0, reg_cnt_cod}, 32'h000012);
        evt_in = 1'b0;
        tick(1);
        check("latency_k4_updated", {8'h0, reg_cnt_cod}, 32'h000013);
        tick(4);

        // 4: carry ripple and wrap/saturate at 999999
        cmd(1'b0, 1'b0, 1'b1);
        tick(3);
        repeat (999) pulse(1, 1);
        tick(5);
        check("preload_999", {8'h0, reg_cnt_cod}, 32'h000999);
        pulse(1, 1);
        tick(5);
        check("ripple_1000", {8'h0, reg_cnt_cod}, 32'h001000);
        cmd(1'b0, 1'b1, 1'b0);
        tick(3);
        force dut.cnt = 24'h999999;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        release dut.cnt;
        tick(2);
        check("forced_999999", {8'h0, reg_cnt_cod}, 32'h999999);
        cmd(1'b1, 1'b0, 1'b0);
        tick(2);
        pulse(1, 1);
        tick(5);
`ifdef BCD_CNT_SATURATE_EN
        check("saturate_cnt", {8'h0, reg_cnt_cod}, 32'h999999);
`else
        check("wrap_cnt", {8'h0, reg_cnt_cod}, 32'h000000);
`endif
        check("wrap_ovf", {31'h0, ovf}, 32'h1);
        pulse(1, 1);
        tick(5);
`ifdef BCD_CNT_SATURATE_EN
        check("saturate_hold", {8'h0, reg_cnt_cod}, 32'h999999);
`else
        check("after_wrap_cnt", {8'h0, reg_cnt_cod}, 32'h000001);
`endif
        check("ovf_sticky", {31'h0, ovf}, 32'h1);

        // 5: clear coincident with an event pulse
        cmd(1'b0, 1'b0, 1'b1);
        tick(2);
        repeat (5) pulse(2, 2);
        tick(4);
        check("pre_clear_5", {8'h0, reg_cnt_cod}, 32'h000005);
        check("pre_clear_ovf", {31'h0, ovf}, 32'h0);
        evt_in = 1'b1;
        tick(3);
        clear = 1'b1;
        tick(1);
        check("clear_coincident_cnt", {8'h0, reg_cnt_cod}, 32'h0);
        check("clear_coincident_ovf", {31'h0, ovf}, 32'h0);
        clear  = 1'b0;
        evt_in = 1'b0;
        tick(4);
        check("clear_event_lost", {8'h0, reg_cnt_cod}, 32'h0);
        check("clear_keeps_run_led", {31'h0, sw_led_ena}, 32'h1);
        pulse(2, 2);
        tick(4);
        check("after_clear_1", {8'h0, reg_cnt_cod}, 32'h000001);

        // 6: start+stop together, then reset mid-run
        cmd(1'b0, 1'b0, 1'b1);
        tick(2);
        repeat (7) pulse(2, 2);
        tick(4);
        cmd(1'b1, 1'b1, 1'b0);
        tick(3);
        check("pair_in_run_holds_7", {8'h0, reg_cnt_cod}, 32'h000007);
        pulse(2, 2);
        tick(4);
        check("pair_hold_ignores", {8'h0, reg_cnt_cod}, 32'h000007);
        cmd(1'b1, 1'b1, 1'b0);
        tick(2);
        pulse(2, 2);
        tick(4);
        check("pair_in_hold_runs_8", {8'h0, reg_cnt_cod}, 32'h000008);
        evt_in = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rst_mid_run_cnt", {8'h0, reg_cnt_cod}, 32'h0);
        check("rst_mid_run_led", {31'h0, sw_led_ena}, 32'h0);
        check("rst_mid_run_ovf", {31'h0, ovf}, 32'h0);
        rst    = 1'b0;
        evt_in = 1'b0;
        tick(6);
        check("rst_no_partial", {8'h0, reg_cnt_cod}, 32'h0);
        check("rst_idle_led", {31'h0, sw_led_ena}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_event_counter.md
Name: bcd_event_counter

Overview:
- Six-digit BCD event counter. It counts rising edges of an asynchronous event input between start and stop commands.
- It produces the 6x4-bit digit array and the display-enable flag consumed by the switch-selected LED digit viewer directly downstream.
- Digit 0 is the least-significant decade.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on evt_in. Legal values are 2 to 4.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- evt_in  input  1  asynchronous event line; each rising edge counts once.
- start  input  1  single-cycle synchronous command: begin or resume counting.
- stop  input  1  single-cycle synchronous command: freeze the count.
- clear  input  1  single-cycle synchronous command: zero the count.
- reg_cnt_cod  output  [5:0][3:0]  registered BCD count, digit i in element i.
- sw_led_ena  output  1  high when reg_cnt_cod holds meaningful data (RUN or HOLD).
- ovf  output  1  sticky flag: the count wrapped past 999999.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State becomes IDLE.
  - Live count, reg_cnt_cod, sw_led_ena and ovf all become 0.
  - All synchroniser and edge-detect flops become 0.
- Input path:
  - evt_in passes through SYNC_STAGES flops, then one edge-detect flop.
  - evt_pulse = sync_out & ~prev, which is one cycle wide.
  - Latency: if evt_in is first sampled high at edge k, the live count increments at edge k+SYNC_STAGES+1. reg_cnt_cod shows the new value at edge k+SYNC_STAGES+2.
- States: IDLE, RUN, HOLD.
  - IDLE: start -> RUN. stop is ignored.
  - RUN: stop -> HOLD. start is ignored.
  - HOLD: start -> RUN, resuming from the held count without clearing. stop is ignored.
- Command priority per cycle: rst > clear > state-transition commands.
  - start and stop both high: only the command valid in the current state acts (stop in RUN, start in IDLE/HOLD).
- clear:
  - Zeros the live count and ovf in every state.
  - reg_cnt_cod reads 0 on the next edge.
  - The state is unchanged.
  - If evt_pulse coincides with clear, clear wins and the event is lost.
- Counting:
  - Only when state==RUN and evt_pulse==1 in the same cycle.
  - An edge pulse arriving in the cycle stop is accepted is still counted, because the state is RUN that cycle.
  - Pulses in IDLE/HOLD are discarded. They are not queued.
- BCD arithmetic:
  - Digit 0 increments. A digit at 9 rolls to 0 and carries to the next digit.
  - The ripple completes in one cycle.
  - Digit values 10 to 15 never occur.
- Wrap:
  - 999999 + 1 = 000000, and ovf is set to 1 on the same edge.
  - ovf stays set until clear or rst.
- reg_cnt_cod:
  - Loaded from the live count every cycle in RUN.
  - In HOLD it keeps the value from the cycle the stop was accepted, including any coincident event.
  - In IDLE it is 0.
- sw_led_ena:
  - Registered.
  - 1 in the cycle after entering RUN or HOLD.
  - 0 the cycle after rst.
- Reset mid-count: rst overrides all commands and pulses. There is no partial increment.

Optional Feature:
- Macro: BCD_CNT_SATURATE_EN.
- Defined:
  - The counter saturates at 999999: further pulses leave it unchanged.
  - ovf is set on the first pulse attempted at 999999.
  - clear still zeros the count and ovf.
- Undefined: wrap-around to 000000 with sticky ovf, as described above.

Test Plan:
1. rst for 2 cycles, then idle 5 cycles -> reg_cnt_cod=000000, sw_led_ena=0, ovf=0. evt_in toggling in IDLE leaves the count at 0.
2. start, then 12 evt_in pulses each 4 cycles high / 4 cycles low, then stop -> HOLD with reg_cnt_cod digits {0,0,0,0,1,2}, sw_led_ena=1. Further pulses leave it unchanged.
3. SYNC_STAGES=2: evt_in rises at edge k while in RUN -> live count increments at edge k+3, reg_cnt_cod updates at edge k+4.
4. Preload via 999 pulses, then one more -> 001000 (the carry ripples through three digits in one cycle). Then force to 999999 and send one pulse -> 000000 with ovf=1. With BCD_CNT_SATURATE_EN defined -> stays 999999 with ovf=1.
5. clear coincident with evt_pulse in RUN at count 000005 -> count 000000, ovf=0, state remains RUN. The next pulse gives 000001.
6. start and stop asserted together in RUN at count 000007 -> HOLD at 000007. Same pair in HOLD -> RUN. rst asserted mid-RUN -> IDLE with all outputs 0 on the next edge.
